// File: rtl/cam_pkg.sv
// Shared camera/frame-buffer definitions: FSM encoding, RGB444 field widths and
// the default decimated frame geometry used by the capture, processing and VGA blocks.
package cam_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_FRAME = 2'd2
  } cam_state_t;

  localparam int CAM_R_W   = 4;
  localparam int CAM_G_W   = 4;
  localparam int CAM_B_W   = 4;
  localparam int CAM_PIX_W = CAM_R_W + CAM_G_W + CAM_B_W;

  localparam int CAM_H_PIX = 160;
  localparam int CAM_V_PIX = 120;
  localparam int CAM_DEC   = 4;

endpackage

// File: rtl/cam_edge_det.sv
// Single-register synchroniser with rise/fall pulses taken against the previous
// registered sample, so edge pulses trail the pin by one cycle.
module cam_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q    <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_q    <= i_sig;
      r_prev <= r_q;
    end
  end

  assign o_lvl  = r_q;
  assign o_rise = r_q & ~r_prev;
  assign o_fall = ~r_q & r_prev;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 RGB444 capture: assembles byte pairs into pixels, decimates by DEC on both
// axes and writes the kept pixels in raster order to the frame buffer write port.
module cam_capture_rgb444
  import cam_pkg::*;
#(
  parameter int AW    = 15,
  parameter int DW    = CAM_PIX_W,
  parameter int H_PIX = CAM_H_PIX,
  parameter int V_PIX = CAM_V_PIX,
  parameter int DEC   = CAM_DEC,
  parameter int SRC_W = 10
) (
  input  logic          clk_w,
  input  logic          reset,
  input  logic          capture_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy
);

  localparam int OCW = $clog2(H_PIX + 1);
  localparam int ORW = $clog2(V_PIX + 1);
  localparam logic [SRC_W-1:0] DEC_MASK  = SRC_W'(DEC - 1);
  localparam logic [SRC_W-1:0] SRC_MAX   = '1;
  localparam logic [OCW-1:0]   H_LIM     = OCW'(H_PIX);
  localparam logic [ORW-1:0]   V_LIM     = ORW'(V_PIX);
  localparam logic [AW-1:0]    LINE_STEP = AW'(H_PIX);

  logic w_vs_lvl, w_vs_rise, w_vs_fall;
  logic w_href_lvl, w_href_rise, w_href_fall;
  logic w_unused;

  cam_edge_det u_vs_edge (
    .i_clk   (clk_w),
    .i_reset (reset),
    .i_sig   (vsync),
    .o_lvl   (w_vs_lvl),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  cam_edge_det u_href_edge (
    .i_clk   (clk_w),
    .i_reset (reset),
    .i_sig   (href),
    .o_lvl   (w_href_lvl),
    .o_rise  (w_href_rise),
    .o_fall  (w_href_fall)
  );

  assign w_unused = w_vs_lvl ^ w_href_rise;

  cam_state_t         r_state;
  logic               r_phase;
  logic [CAM_R_W-1:0] r_red;
  logic [7:0]         r_px_p0;
  logic [SRC_W-1:0]   r_src_col;
  logic [SRC_W-1:0]   r_src_line;
  logic [OCW-1:0]     r_out_col;
  logic [ORW-1:0]     r_out_row;
  logic [AW-1:0]      r_line_base;

  logic                 w_line_kept;
  logic                 w_keep;
  logic [AW-1:0]        w_addr;
  logic [CAM_PIX_W-1:0] w_pix;

  assign w_line_kept = ((r_src_line & DEC_MASK) == '0) && (r_out_row < V_LIM);
  assign w_keep      = w_line_kept && ((r_src_col & DEC_MASK) == '0) && (r_out_col < H_LIM);
  assign w_addr      = r_line_base + AW'(r_out_col);
  assign w_pix       = {r_red, r_px_p0};

  // p0: data bus registered alongside the synchronised href
  always_ff @(posedge clk_w) begin
    r_px_p0 <= px_data;
    if (r_state == S_FRAME && w_href_lvl && !r_phase) begin
      r_red <= r_px_p0[CAM_R_W-1:0];
    end
  end

  // p1: framing FSM, counters and registered write port
  always_ff @(posedge clk_w) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_src_col   <= '0;
      r_src_line  <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_line_base <= '0;
      addr_in     <= '0;
      data_in     <= '0;
      regwrite    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_rise && capture_en) begin
            r_state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_vs_fall) begin
            r_state     <= S_FRAME;
            busy        <= 1'b1;
            r_phase     <= 1'b0;
            r_src_col   <= '0;
            r_src_line  <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_line_base <= '0;
          end
        end
        S_FRAME: begin
          if (w_href_lvl) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              if (w_keep) begin
                regwrite  <= 1'b1;
                addr_in   <= w_addr;
                data_in   <= DW'(w_pix);
                r_out_col <= r_out_col + 1'b1;
              end
              if (r_src_col != SRC_MAX) begin
                r_src_col <= r_src_col + 1'b1;
              end
            end
          end else if (w_href_fall) begin
            r_phase   <= 1'b0;
            r_src_col <= '0;
            if (r_src_line != SRC_MAX) begin
              r_src_line <= r_src_line + 1'b1;
            end
            if (w_line_kept) begin
              r_out_row   <= r_out_row + 1'b1;
              r_line_base <= r_line_base + LINE_STEP;
              r_out_col   <= '0;
            end
          end
          // Frame end overrides line bookkeeping; a half-assembled pixel is dropped.
          if (w_vs_rise) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_phase    <= 1'b0;
            r_state    <= capture_en ? S_SYNC : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Randomised frame bench for cam_capture_rgb444 with a per-pixel keep/address model.
module tb_cam_capture_rgb444;

  localparam int H   = 160;
  localparam int V   = 120;
  localparam int DEC = 4;

  logic        clk_w = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic [14:0] addr_in;
  logic [11:0] data_in;
  logic        regwrite;
  logic        frame_done;
  logic        busy;

  cam_capture_rgb444 dut (
    .clk_w      (clk_w),
    .reset      (reset),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk_w = ~clk_w;

  int cyc = 0;
  always @(posedge clk_w) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  int exp_a[$], exp_d[$];
  int obs_a[$], obs_d[$], obs_c[$];
  int fd_cnt, busy_cnt;
  bit model_on;
  bit force_first = 1'b0;
  int sample_cyc = -1000;
  int v48 = -1;
  int lw[500];

  always @(negedge clk_w) begin
    if (regwrite) begin
      obs_a.push_back(int'(addr_in));
      obs_d.push_back(int'(data_in));
      obs_c.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: source pixel (line, col) lands at (line/DEC)*H + col/DEC when aligned and in range.
  function automatic void expect_pix(input int line, input int col, input int val);
    if (line == 4 && col == 8) v48 = val;
    if (model_on && (line % DEC == 0) && (col % DEC == 0) && (col / DEC < H) && (line / DEC < V)) begin
      exp_a.push_back((line / DEC) * H + col / DEC);
      exp_d.push_back(val);
    end
  endfunction

  task automatic send_line(input int line, input int nbytes, input bit last, input bit vs_mode);
    logic [7:0] b;
    logic [3:0] red;
    red = 4'h0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      if (force_first && line == 0 && i == 0) b = 8'h0A;
      if (force_first && line == 0 && i == 1) b = 8'hBC;
      @(negedge clk_w);
      href    = 1'b1;
      px_data = b;
      if (force_first && line == 0 && i == 1) sample_cyc = cyc + 1;
      if (last && !vs_mode && i == nbytes - 1) vsync = 1'b1;
      if (i % 2 == 0) red = b[3:0];
      else expect_pix(line, i / 2, int'({red, b}));
    end
    @(negedge clk_w);
    href    = 1'b0;
    px_data = 8'($urandom);
    if (last) vsync = 1'b1;
    else repeat (2) @(negedge clk_w);
  endtask

  task automatic fill_narrow();
    for (int l = 0; l < 500; l++) lw[l] = int'($urandom_range(2, 12));
  endtask

  task automatic run_frame(input int nlines, input bit cap, input int reset_line,
                           input int en_line, input bit en_val, input bit vs_mode);
    exp_a.delete(); exp_d.delete();
    obs_a.delete(); obs_d.delete(); obs_c.delete();
    fd_cnt   = 0;
    busy_cnt = 0;
    model_on = cap;
    @(negedge clk_w);
    vsync = 1'b0;
    repeat (3) @(negedge clk_w);
    for (int l = 0; l < nlines; l++) begin
      if (l == reset_line) begin
        reset = 1'b1;
        @(negedge clk_w);
        chk("rst_mid_regwrite", regwrite, 0);
        chk("rst_mid_addr", addr_in, 0);
        chk("rst_mid_data", data_in, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frame_done", frame_done, 0);
        reset    = 1'b0;
        model_on = 1'b0;
      end
      if (l == en_line) capture_en = en_val;
      send_line(l, lw[l], l == nlines - 1, vs_mode);
    end
    repeat (5) @(negedge clk_w);
  endtask

  task automatic check_frame(input string tag, input int exp_fd);
    int bad, order_bad, range_bad, n;
    bad = 0; order_bad = 0; range_bad = 0;
    chk({tag, "_nwrites"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++)
      if (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]) bad++;
    for (int i = 0; i < obs_a.size(); i++) begin
      if (i > 0 && obs_a[i] <= obs_a[i-1]) order_bad++;
      if (obs_a[i] >= H * V) range_bad++;
    end
    chk({tag, "_addr_data_diffs"}, bad, 0);
    chk({tag, "_addr_not_increasing"}, order_bad, 0);
    chk({tag, "_addr_out_of_range"}, range_bad, 0);
    chk({tag, "_frame_done_pulses"}, fd_cnt, exp_fd);
  endtask

  function automatic int count_range(input int lo, input int hi);
    int c = 0;
    foreach (obs_a[i]) if (obs_a[i] >= lo && obs_a[i] < hi) c++;
    return c;
  endfunction

  function automatic int data_at(input int addr);
    foreach (obs_a[i]) if (obs_a[i] == addr) return obs_d[i];
    return -1;
  endfunction

  function automatic int first_at_or_above(input int addr);
    foreach (obs_a[i]) if (obs_a[i] >= addr) return obs_a[i];
    return -1;
  endfunction

  initial begin
    reset = 1'b1; capture_en = 1'b1; vsync = 1'b0; href = 1'b0; px_data = 8'h00;
    repeat (3) @(negedge clk_w);
    chk("reset_regwrite", regwrite, 0);
    chk("reset_addr", addr_in, 0);
    chk("reset_data", data_in, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk_w);
    vsync = 1'b1;
    repeat (4) @(negedge clk_w);

    // Frame 1: wide/odd/over-long lines plus a tall frame; href fall coincides with vsync rise
    fill_narrow();
    lw[0] = 1280; lw[4] = 1280; lw[5] = 1280; lw[8] = 641; lw[12] = 1600; lw[476] = 1280;
    run_frame(490, 1'b1, -1, -1, 1'b0, 1'b1);
    check_frame("f1", 1);
    chk("f1_row0_writes", count_range(0, 160), 160);
    chk("f1_row2_odd_line_writes", count_range(320, 480), 80);
    chk("f1_row3_wide_line_writes", count_range(480, 640), 160);
    chk("f1_row4_line_base", first_at_or_above(640), 640);
    chk("f1_pix_4_8_at_162", data_at(162), v48);
    chk("f1_last_addr", obs_a.size() > 0 ? obs_a[obs_a.size()-1] : -1, H * V - 1);
    chk("f1_busy_seen", busy_cnt > 0, 1);

    // Frame 2: short frame, capture_en dropped mid-frame, kept byte alongside vsync rise
    fill_narrow();
    lw[128] = 2;
    run_frame(129, 1'b1, -1, 60, 1'b0, 1'b0);
    check_frame("f2", 1);
    chk("f2_last_addr", obs_a.size() > 0 ? obs_a[obs_a.size()-1] : -1, 32 * H);

    // Frame 3: disarmed; capture_en raised mid-frame arms the next one
    fill_narrow();
    run_frame(40, 1'b0, -1, 20, 1'b1, 1'b0);
    check_frame("f3", 0);
    chk("f3_busy_cycles", busy_cnt, 0);

    // Frame 4: first pixel 0x0A,0xBC and write latency
    force_first = 1'b1;
    fill_narrow();
    lw[0] = 16; lw[16] = 2;
    run_frame(17, 1'b1, -1, -1, 1'b0, 1'b0);
    force_first = 1'b0;
    check_frame("f4", 1);
    chk("f4_first_addr", obs_a.size() > 0 ? obs_a[0] : -1, 0);
    chk("f4_first_data", obs_d.size() > 0 ? obs_d[0] : -1, 12'hABC);
    chk("f4_write_latency", obs_c.size() > 0 ? obs_c[0] - sample_cyc : -1, 1);

    // Frame 5: reset at row 50 abandons the frame
    fill_narrow();
    run_frame(220, 1'b1, 200, -1, 1'b0, 1'b0);
    check_frame("f5", 0);

    // Frame 6: full recovery from address 0 to the last address
    fill_narrow();
    lw[0] = 1280; lw[476] = 1280;
    run_frame(484, 1'b1, -1, -1, 1'b0, 1'b1);
    check_frame("f6", 1);
    chk("f6_first_addr", obs_a.size() > 0 ? obs_a[0] : -1, 0);
    chk("f6_last_addr", obs_a.size() > 0 ? obs_a[obs_a.size()-1] : -1, H * V - 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_capture_rgb444.md
Name: cam_capture_rgb444

Overview:
Camera-side writer for the shared frame buffer. Samples the OV7670 8-bit pixel bus (VSYNC/HREF framing, RGB444 as two bytes per pixel) and decimates 640x480 down to 160x120. It drives the buffer's write port (addr_in, data_in, regwrite) in raster order starting at address 0. It also flags frame boundaries for the processing and VGA side.

Parameters:
AW, 15, write-address width; must match the frame buffer.
DW, 12, pixel width (RGB444).
H_PIX, 160, output pixels per line.
V_PIX, 120, output lines per frame.
DEC, 4, decimation factor on both axes; power of two, 1..8.
SRC_W, 10, width of the source column/line counters.

Ports:
clk_w  in  1  camera PCLK; all logic on rising edge.
reset  in  1  synchronous, active-high.
capture_en  in  1  arms capture; sampled only at frame start.
vsync  in  1  camera VSYNC; high = vertical blanking.
href  in  1  camera HREF; high = valid bytes on px_data.
px_data  in  8  camera data bus.
addr_in  out  AW  buffer write address.
data_in  out  DW  buffer write data {R,G,B}.
regwrite  out  1  buffer write enable; one-cycle pulse per pixel.
frame_done  out  1  one-cycle pulse at the end of a captured frame.
busy  out  1  high while in S_FRAME.

Behaviour:
- Reset: all outputs 0; FSM to S_IDLE; counters, byte phase and edge-detect registers cleared. Reset mid-frame abandons the frame with no frame_done.
- vsync and href are registered once. Edges are detected against the previous registered value, so edge response lags the pin by 1 cycle.
- FSM:
  - S_IDLE: on vsync rising edge with capture_en=1, go to S_SYNC.
  - S_SYNC: on vsync falling edge, go to S_FRAME. Clear src_col, src_line, out_col, out_row, line_base and byte phase.
  - S_FRAME, on vsync rising edge:
    - pulse frame_done.
    - go to S_SYNC if capture_en=1, else S_IDLE.
    - a pending partial pixel is discarded.
- Byte assembly (S_FRAME, href=1):
  - phase 0: latch px_data[3:0] as R.
  - phase 1: pixel = {R, px_data[7:4] (G), px_data[3:0] (B)}, then src_col++.
  - Phase toggles every href-high cycle.
- On href falling edge:
  - phase resets to 0; an odd trailing byte is dropped.
  - src_col := 0; src_line++.
  - If the finished line was a kept line: out_row++, line_base += H_PIX, out_col := 0.
- Keep rule: a pixel is written only if all of the following hold:
  - src_col mod DEC == 0
  - src_line mod DEC == 0
  - out_col < H_PIX
  - out_row < V_PIX
- Write timing:
  - Each kept pixel increments out_col.
  - Address = line_base + out_col; accumulator, no multiplier.
  - regwrite, addr_in and data_in are registered. They are valid the cycle after the phase-1 byte is sampled (latency 1).
  - addr_in and data_in hold their last value when regwrite=0.
- Boundaries:
  - Lines longer than H_PIX*DEC and frames taller than V_PIX*DEC produce no extra writes.
  - Counters saturate at 2^SRC_W-1 and do not wrap.
  - Maximum address written is H_PIX*V_PIX-1 (19199). Addresses 19200 and above are never written; they are reserved for the consumer side.
- Short frames: vsync rising before V_PIX kept lines still pulses frame_done. Rows not reached keep stale data.
- capture_en falling mid-frame: the current frame completes; the FSM returns to S_IDLE afterwards.
- Simultaneous events:
  - href falling and vsync rising in the same cycle: the vsync action wins; the line counter update is irrelevant.
  - A phase-1 byte on the last href-high cycle before a vsync edge is still written.

Decomposition:
- Shared package cam_pkg holds:
  - state encoding S_IDLE, S_SYNC, S_FRAME (2 bits);
  - RGB444 field widths;
  - default H_PIX/V_PIX/DEC constants, also used by the VGA and processing blocks.
- One natural sub-module: cam_edge_det (registered sync plus rise/fall pulses), instantiated for vsync and href.

Test Plan:
1. Full 640x480 synthetic frame, pixel value = (line,col) pattern, capture_en=1 → exactly 19200 regwrite pulses, addresses 0..19199 strictly increasing, frame_done pulses once after vsync rise.
2. Bytes 0x0A then 0xBC as source pixel (0,0) → addr_in=0, data_in=12'hABC, regwrite high exactly 1 cycle after the 0xBC sample.
3. Source pixel (4,8) → written at address 1*160+2=162; source pixel (5,8) → never written.
4. capture_en=0 for a whole frame → zero writes, frame_done stays 0, busy stays 0; raise capture_en → capture begins at the next vsync rise/fall pair.
5. Line with 641 bytes plus an 800-pixel-wide line → odd byte dropped, at most 160 writes per line, next line starts at the correct line_base.
6. Reset asserted mid-frame at row 50, then released → all outputs 0, no frame_done; next full frame writes from address 0.
